// File: rtl/dp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dp_sequencer
//  Description : Upstream sequencer for the altitude/battery datapath. Takes
//                one sensor sample per valid/ready handshake, drives it onto
//                the datapath operands, issues the altitude then battery
//                evaluation and returns both results as one output record.
//  Revision    : 1.0 - initial release
// ============================================================================
module dp_sequencer #(
    parameter int DP_LATENCY = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_x1,
    input  logic [7:0]        s_x2,
    input  logic [7:0]        s_v,
    input  logic [7:0]        s_t,
    input  logic [7:0]        s_c,
    output logic [7:0]        dp_x1,
    output logic [7:0]        dp_x2,
    output logic [7:0]        dp_v,
    output logic [7:0]        dp_t,
    output logic [7:0]        dp_c,
    output logic              dp_sel_eq,
    input  logic [15:0]       dp_result_a,
    input  logic [15:0]       dp_result_b,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [15:0]       m_alt,
    output logic [15:0]       m_bat,
    output logic              busy,
    output logic [CNT_W-1:0]  sample_cnt
);

    // Issue counter only has to reach DP_LATENCY+1.
    localparam int                c_CW    = $clog2(DP_LATENCY + 2);
    localparam logic [c_CW-1:0]   c_CAP_A = c_CW'(DP_LATENCY);
    localparam logic [c_CW-1:0]   c_CAP_B = c_CW'(DP_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ALT  = 3'd1,
        S_BAT  = 3'd2,
        S_WAIT = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [c_CW-1:0]    r_cnt;
    logic [7:0]         r_x1, r_x2, r_v, r_t, r_c;
    logic [15:0]        r_alt, r_bat;
    logic [CNT_W-1:0]   r_sample_cnt;
    logic               w_accept;
    logic               w_done;

    assign w_accept = (r_state == S_IDLE) && s_valid;
    assign w_done   = (r_state == S_OUT) && m_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded handshake/control outputs.
    always_comb begin
        w_next    = r_state;
        s_ready   = 1'b0;
        busy      = 1'b1;
        dp_sel_eq = 1'b0;
        m_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid) begin
                    w_next = S_ALT;
                end
            end
            S_ALT: begin
                w_next = S_BAT;
            end
            S_BAT: begin
                dp_sel_eq = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == c_CAP_B) begin
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand latch, issue counter and result capture; the counter starts at
    // zero in ALT so r_cnt equals the cycles elapsed since the altitude issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_x1  <= '0;
            r_x2  <= '0;
            r_v   <= '0;
            r_t   <= '0;
            r_c   <= '0;
            r_alt <= '0;
            r_bat <= '0;
        end else begin
            if (w_accept) begin
                r_x1  <= s_x1;
                r_x2  <= s_x2;
                r_v   <= s_v;
                r_t   <= s_t;
                r_c   <= s_c;
                r_cnt <= '0;
            end else if ((r_state == S_ALT) || (r_state == S_BAT) || (r_state == S_WAIT)) begin
                r_cnt <= r_cnt + c_CW'(1);
            end
            if (((r_state == S_BAT) || (r_state == S_WAIT)) && (r_cnt == c_CAP_A)) begin
                r_alt <= dp_result_a;
            end
            if ((r_state == S_WAIT) && (r_cnt == c_CAP_B)) begin
                r_bat <= dp_result_b;
            end
        end
    end

    // Completed-record counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_cnt <= '0;
        end else if (w_done) begin
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
        end
    end

    assign dp_x1      = r_x1;
    assign dp_x2      = r_x2;
    assign dp_v       = r_v;
    assign dp_t       = r_t;
    assign dp_c       = r_c;
    assign m_alt      = r_alt;
    assign m_bat      = r_bat;
    assign sample_cnt = r_sample_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dp_sequencer
//  Description : Self-checking bench for dp_sequencer with a behavioural
//                datapath and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_sequencer;

    localparam int DP_LATENCY = 2;
    localparam int CNT_W      = 2;

    typedef struct {
        logic [15:0] alt;
        logic [15:0] bat;
        int          acc;
    } rec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [7:0]        s_x1 = '0, s_x2 = '0, s_v = '0, s_t = '0, s_c = '0;
    logic [7:0]        dp_x1, dp_x2, dp_v, dp_t, dp_c;
    logic              dp_sel_eq;
    logic [15:0]       dp_result_a, dp_result_b;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [15:0]       m_alt, m_bat;
    logic              busy;
    logic [CNT_W-1:0]  sample_cnt;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                cyc      = 0;
    rec_t              q[$];
    logic [7:0]        l_x1 = '0, l_x2 = '0, l_v = '0, l_t = '0, l_c = '0;
    logic [CNT_W-1:0]  exp_cnt = '0;
    logic [15:0]       pa [DP_LATENCY];
    logic [15:0]       pb [DP_LATENCY];

    always #5 clk = ~clk;

    dp_sequencer #(
        .DP_LATENCY (DP_LATENCY),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_x1        (s_x1),
        .s_x2        (s_x2),
        .s_v         (s_v),
        .s_t         (s_t),
        .s_c         (s_c),
        .dp_x1       (dp_x1),
        .dp_x2       (dp_x2),
        .dp_v        (dp_v),
        .dp_t        (dp_t),
        .dp_c        (dp_c),
        .dp_sel_eq   (dp_sel_eq),
        .dp_result_a (dp_result_a),
        .dp_result_b (dp_result_b),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_alt       (m_alt),
        .m_bat       (m_bat),
        .busy        (busy),
        .sample_cnt  (sample_cnt)
    );

    function automatic logic [15:0] f_alt(input logic [7:0] x1, input logic [7:0] x2);
        byte b1, b2;
        b1 = x1;
        b2 = x2;
        return 16'(3 * int'(b1) + 5 * int'(b2));
    endfunction

    function automatic logic [15:0] f_bat(input logic [7:0] v, input logic [7:0] t, input logic [7:0] c);
        byte bv, bt, bc;
        bv = v;
        bt = t;
        bc = c;
        return 16'(int'(bv) * int'(bt) + int'(bc));
    endfunction

    // Datapath model: a result is only meaningful when the right equation is
    // issued in the right cycle after an accept; everything else is noise.
    always @(posedge clk) begin
        logic ok_a, ok_b;
        ok_a = (q.size() != 0) && (cyc == q[0].acc + 1) && !dp_sel_eq;
        ok_b = (q.size() != 0) && (cyc == q[0].acc + 2) && dp_sel_eq;
        pa[0] <= ok_a ? f_alt(dp_x1, dp_x2) : 16'($urandom);
        pb[0] <= ok_b ? f_bat(dp_v, dp_t, dp_c) : 16'($urandom);
        for (int i = 1; i < DP_LATENCY; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end
    assign dp_result_a = pa[DP_LATENCY-1];
    assign dp_result_b = pb[DP_LATENCY-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Compare every output against the transaction model for the current cycle.
    task automatic check_outputs();
        bit pend;
        int acc;
        pend = (q.size() != 0);
        acc  = pend ? q[0].acc : 0;
        check("s_ready",    32'(s_ready),    32'(!pend));
        check("busy",       32'(busy),       32'(pend));
        check("m_valid",    32'(m_valid),    32'(pend && (cyc >= acc + 5)));
        check("dp_sel_eq",  32'(dp_sel_eq),  32'(pend && (cyc == acc + 2)));
        check("sample_cnt", 32'(sample_cnt), 32'(exp_cnt));
        check("dp_ops",     {dp_x1, dp_x2, dp_v, dp_t}, {l_x1, l_x2, l_v, l_t});
        check("dp_c",       32'(dp_c),       32'(l_c));
        if (pend && (cyc >= acc + 5)) begin
            check("m_alt", 32'(m_alt), 32'(q[0].alt));
            check("m_bat", 32'(m_bat), 32'(q[0].bat));
        end
    endtask

    // One clock: log handshakes seen before the edge, then check after it.
    task automatic clk_step();
        if (!rst) begin
            if (s_valid && s_ready) begin
                q.push_back('{alt: f_alt(s_x1, s_x2), bat: f_bat(s_v, s_t, s_c), acc: cyc});
                l_x1 = s_x1; l_x2 = s_x2; l_v = s_v; l_t = s_t; l_c = s_c;
            end
            if (m_valid && m_ready && (q.size() != 0)) begin
                void'(q.pop_front());
                exp_cnt = exp_cnt + CNT_W'(1);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) check_outputs();
    endtask

    task automatic send(input logic [7:0] x1, input logic [7:0] x2, input logic [7:0] v,
                        input logic [7:0] t, input logic [7:0] c);
        bit took;
        took = 1'b0;
        s_valid = 1'b1;
        s_x1 = x1; s_x2 = x2; s_v = v; s_t = t; s_c = c;
        for (int i = 0; i < 64 && !took; i++) begin
            took = s_ready;
            clk_step();
        end
        if (!took) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && q.size() != 0; i++) clk_step();
        if (q.size() != 0) begin
            check("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        #1;
        check("rst_m_valid",    32'(m_valid),    32'd0);
        check("rst_s_ready",    32'(s_ready),    32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_sample_cnt", 32'(sample_cnt), 32'd0);
        q.delete();
        exp_cnt = '0;
        l_x1 = '0; l_x2 = '0; l_v = '0; l_t = '0; l_c = '0;
        clk_step();
        clk_step();
        rst = 1'b0;
        check_outputs();
    endtask

    initial begin
        int seq [5];
        seq = '{1, 2, 3, 0, 1};

        // Reset state
        do_reset();
        check("rst_dp_x1", 32'(dp_x1), 32'd0);

        // Single sample, consumer always ready
        m_ready = 1'b1;
        send(8'd3, 8'd4, 8'd2, 8'd5, 8'd16);
        s_valid = 1'b0;
        drain();
        check("t2_alt", 32'(m_alt), 32'd29);
        check("t2_bat", 32'(m_bat), 32'd26);

        // Signed operands, then a second sample with s_valid held high
        send(8'hFB, 8'd7, 8'hFD, 8'hFE, 8'd10);
        send(8'd10, 8'd15, 8'd12, 8'd8, 8'd20);
        s_valid = 1'b0;
        drain();
        check("t3_alt", 32'(m_alt), 32'd105);
        check("t3_bat", 32'(m_bat), 32'd116);

        // Back-pressure: record held while the consumer stalls
        m_ready = 1'b0;
        send(8'h80, 8'h7F, 8'h80, 8'h80, 8'h7F);
        s_valid = 1'b1;
        for (int i = 0; i < 15; i++) clk_step();
        check("t4_held", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        s_valid = 1'b0;
        clk_step();
        check("t4_ready_after", 32'(s_ready), 32'd1);

        // Reset asserted while waiting on results
        send(8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
        s_valid = 1'b0;
        clk_step();
        clk_step();
        do_reset();
        for (int i = 0; i < 6; i++) clk_step();
        send(8'd9, 8'hF7, 8'd11, 8'hF5, 8'd1);
        s_valid = 1'b0;
        drain();
        check("t5_cnt", 32'(sample_cnt), 32'd1);

        // Counter wrap with a 2-bit sample_cnt
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            s_valid = 1'b0;
            drain();
            check("t6_wrap", 32'(sample_cnt), 32'(seq[i]));
        end

        // Randomised traffic on both handshakes
        for (int i = 0; i < 400; i++) begin
            s_valid = ($urandom_range(0, 9) < 7);
            s_x1 = 8'($urandom); s_x2 = 8'($urandom);
            s_v  = 8'($urandom); s_t  = 8'($urandom); s_c = 8'($urandom);
            m_ready = ($urandom_range(0, 9) < 6);
            clk_step();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
